// File: rtl/bb_bus_ctrl.sv
// rtl/bb_bus_ctrl.sv - address-decoded, ready-handshaked device bus controller for the bb core data port
module bb_bus_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEV_NUM    = 4,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_core_ren,
    input  logic                          i_core_wen,
    input  logic [DATA_WIDTH-1:0]         i_core_addr,
    input  logic [DATA_WIDTH-1:0]         i_core_wdata,
    output logic [DATA_WIDTH-1:0]         o_core_rdata,
    output logic                          o_core_busy,
    output logic                          o_core_done,
    output logic                          o_core_err,
    output logic [DEV_NUM-1:0]            o_dev_oen,
    output logic [DEV_NUM-1:0]            o_dev_ien,
    output logic [DATA_WIDTH-1:0]         o_dev_addr,
    output logic [DATA_WIDTH-1:0]         o_dev_data,
    input  logic [DEV_NUM*DATA_WIDTH-1:0] i_dev_data,
    input  logic [DEV_NUM-1:0]            i_dev_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR} state_t;

    localparam logic [SEL_W:0] DEV_LIM = (SEL_W + 1)'(DEV_NUM);
    localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);

    state_t                  state, state_next;
    logic [SEL_W-1:0]        req_sel, sel_q;
    logic                    rd_q;
    logic [7:0]              cnt;
    logic [DATA_WIDTH-1:0]   addr_q, wdata_q, rdata_q, rd_mux;
    logic                    done_q;
    logic [DEV_NUM-1:0]      sel_oh;
    logic                    ready_hit, req_any, req_bad;

    assign req_sel = i_core_addr[DATA_WIDTH-1 -: SEL_W];
    assign req_any = i_core_ren | i_core_wen;
    assign req_bad = (i_core_ren & i_core_wen) || ({1'b0, req_sel} >= DEV_LIM);

    // Latched selector drives both the strobe one-hot and the read-data mux.
    always_comb begin
        sel_oh = '0;
        rd_mux = '0;
        for (int k = 0; k < DEV_NUM; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
                rd_mux    = i_dev_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ready_hit = |(i_dev_ready & sel_oh);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_any) state_next = req_bad ? ST_ERR : ST_ACCESS;
            ST_ACCESS: begin
                if (ready_hit)            state_next = ST_IDLE;
                else if (cnt == TO_LAST)  state_next = ST_ERR;
            end
            ST_ERR:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            rd_q    <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE && req_any && !req_bad) begin
                sel_q   <= req_sel;
                rd_q    <= i_core_ren;
                addr_q  <= i_core_addr;
                wdata_q <= i_core_wdata;
                cnt     <= '0;
            end
            if (state == ST_ACCESS) begin
                if (ready_hit) begin
                    done_q <= 1'b1;
                    if (rd_q) rdata_q <= rd_mux;
                end else if (cnt != TO_LAST) begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign o_core_rdata = rdata_q;
    assign o_core_busy  = (state == ST_ACCESS);
    assign o_core_done  = done_q;
    assign o_core_err   = (state == ST_ERR);
    assign o_dev_oen    = (o_core_busy &&  rd_q) ? sel_oh : '0;
    assign o_dev_ien    = (o_core_busy && !rd_q) ? sel_oh : '0;
    assign o_dev_addr   = addr_q;
    assign o_dev_data   = wdata_q;

endmodule
